collision_arbiter: RTL and testbench

//  Game-state stage consuming player car position (car FSM) and rival car position (rival generator).

---
 rtl/collision_arbiter.sv | 169 ++++++++++++++++
 tb/tb_collision_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/collision_arbiter.sv
// Game-state stage: per-frame bounding-box collision, lives, score and freeze/flash/game-over control.
// Optional high-score tracking is enabled by defining COLLIDE_HIGH_SCORE_EN.
module collision_arbiter #(
  parameter int unsigned CarW      = 32,
  parameter int unsigned CarH      = 64,
  parameter int unsigned RivalW    = 32,
  parameter int unsigned RivalH    = 64,
  parameter int unsigned Lives     = 3,
  parameter int unsigned HitFrames = 60,
  parameter int unsigned ScoreW    = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              frame_tick_i,
  input  logic [9:0]        car_x_i,
  input  logic [9:0]        car_y_i,
  input  logic [9:0]        rival_x_i,
  input  logic [9:0]        rival_y_i,
  input  logic              rival_respawn_i,
  input  logic              restart_i,
  output logic              collision_o,
  output logic              hit_pulse_o,
  output logic              freeze_o,
  output logic              flash_o,
  output logic              game_over_o,
  output logic [1:0]        lives_o,
  output logic [ScoreW-1:0] score_o,
  output logic [ScoreW-1:0] high_score_o
);

  // Counter must reach bit 3 for the flash cadence even for short hit windows.
  localparam int unsigned CntW = ($clog2(HitFrames) > 4) ? $clog2(HitFrames) : 4;
  localparam logic [CntW-1:0] HitLast   = CntW'(HitFrames - 1);
  localparam logic [1:0]      LivesInit = 2'(Lives);

  typedef enum logic [1:0] {StPlay, StHit, StOver} state_e;

  logic [9:0]        cx_q, cy_q, rx_q, ry_q;
  logic              smp_vld_q, ovl_vld_q, ovl_q, overlap;
  logic              collision_q, hit_pulse_q, hit_pulse_d;
  state_e            state_q, state_d;
  logic [1:0]        lives_q, lives_d;
  logic [ScoreW-1:0] score_q, score_d;
  logic [CntW-1:0]   hit_cnt_q, hit_cnt_d;

  // Stage 1: sample coordinates on frame_tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      smp_vld_q <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
    end else if (restart_i) begin
      smp_vld_q <= 1'b0;
    end else begin
      smp_vld_q <= frame_tick_i;
      if (frame_tick_i) begin
        cx_q <= car_x_i;
        cy_q <= car_y_i;
        rx_q <= rival_x_i;
        ry_q <= rival_y_i;
      end
    end
  end

  // Strict compares: boxes that only share an edge do not collide.
  assign overlap = ({1'b0, cx_q} < ({1'b0, rx_q} + 11'(RivalW))) &&
                   ({1'b0, rx_q} < ({1'b0, cx_q} + 11'(CarW)))   &&
                   ({1'b0, cy_q} < ({1'b0, ry_q} + 11'(RivalH))) &&
                   ({1'b0, ry_q} < ({1'b0, cy_q} + 11'(CarH)));

  // Stages 2 and 3: registered overlap, then the visible collision flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovl_vld_q   <= 1'b0;
      ovl_q       <= 1'b0;
      collision_q <= 1'b0;
    end else if (restart_i) begin
      ovl_vld_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      ovl_vld_q <= smp_vld_q;
      if (smp_vld_q) ovl_q <= overlap;
      if (ovl_vld_q) collision_q <= ovl_q;
    end
  end

`ifdef COLLIDE_HIGH_SCORE_EN
  logic [ScoreW-1:0] high_score_q, high_score_d;
`endif

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    hit_cnt_d   = hit_cnt_q;
    hit_pulse_d = 1'b0;
`ifdef COLLIDE_HIGH_SCORE_EN
    high_score_d = high_score_q;
`endif
    if (restart_i) begin
      state_d   = StPlay;
      lives_d   = LivesInit;
      score_d   = '0;
      hit_cnt_d = '0;
    end else begin
      unique case (state_q)
        StPlay: begin
          // A hit in the same cycle as a respawn suppresses the score increment.
          if (ovl_vld_q && ovl_q) begin
            lives_d     = lives_q - 2'd1;
            hit_pulse_d = 1'b1;
            hit_cnt_d   = '0;
            state_d     = (lives_d == 2'd0) ? StOver : StHit;
`ifdef COLLIDE_HIGH_SCORE_EN
            if (lives_d == 2'd0 && score_q > high_score_q) high_score_d = score_q;
`endif
          end else if (rival_respawn_i && (score_q != '1)) begin
            score_d = score_q + ScoreW'(1);
          end
        end
        StHit: begin
          if (frame_tick_i) begin
            hit_cnt_d = hit_cnt_q + CntW'(1);
            if (hit_cnt_q == HitLast) state_d = StPlay;
          end
        end
        StOver: ;
        default: state_d = StPlay;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StPlay;
      lives_q     <= LivesInit;
      score_q     <= '0;
      hit_cnt_q   <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      hit_cnt_q   <= hit_cnt_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

`ifdef COLLIDE_HIGH_SCORE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) high_score_q <= '0;
    else         high_score_q <= high_score_d;
  end
  assign high_score_o = high_score_q;
`else
  assign high_score_o = '0;
`endif

  assign collision_o = collision_q;
  assign hit_pulse_o = hit_pulse_q;
  assign freeze_o    = (state_q != StPlay);
  assign flash_o     = (state_q == StHit) && hit_cnt_q[3];
  assign game_over_o = (state_q == StOver);
  assign lives_o     = lives_q;
  assign score_o     = score_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Scoreboard bench for collision_arbiter: stimulus pushes expected state, a negedge monitor
// pops and compares two cycles after each sampled frame (or on explicit snapshot requests).
module tb_collision_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0, rival_respawn = 1'b0, restart = 1'b0;
  logic [9:0]  car_x = '0, car_y = '0, rival_x = '0, rival_y = '0;
  logic        collision, hit_pulse, freeze, flash, game_over;
  logic [1:0]  lives;
  logic [13:0] score, high_score;

  always #5 clk = ~clk;

  collision_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .frame_tick_i   (frame_tick),
    .car_x_i        (car_x),
    .car_y_i        (car_y),
    .rival_x_i      (rival_x),
    .rival_y_i      (rival_y),
    .rival_respawn_i(rival_respawn),
    .restart_i      (restart),
    .collision_o    (collision),
    .hit_pulse_o    (hit_pulse),
    .freeze_o       (freeze),
    .flash_o        (flash),
    .game_over_o    (game_over),
    .lives_o        (lives),
    .score_o        (score),
    .high_score_o   (high_score)
  );

  typedef struct {
    string       name;
    logic        col, hp, frz, fl, go;
    logic [1:0]  lives;
    logic [13:0] score, hs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   m_lives = 3, m_score = 0, m_hs = 0;
  logic snap = 1'b0;
  logic [2:0] tick_pipe = '0;

  task automatic chk(input string nm, input string f, input logic [13:0] act,
                     input logic [13:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, req);
    end
  endtask

  // Monitor: a frame result is visible at the third negedge after its tick was seen.
  initial forever begin
    @(negedge clk);
    if (rst_n && (tick_pipe[2] || snap)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got output with no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, "collision", 14'(collision), 14'(e.col));
        chk(e.name, "hit_pulse", 14'(hit_pulse), 14'(e.hp));
        chk(e.name, "freeze",    14'(freeze),    14'(e.frz));
        chk(e.name, "flash",     14'(flash),     14'(e.fl));
        chk(e.name, "game_over", 14'(game_over), 14'(e.go));
        chk(e.name, "lives",     14'(lives),     14'(e.lives));
        chk(e.name, "score",     score,          e.score);
        chk(e.name, "high_score", high_score,    e.hs);
      end
    end
    tick_pipe = {tick_pipe[1:0], frame_tick};
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 20000 cycles");
    $fatal(1);
  end

  task automatic push(input string nm, input logic col, hp, frz, fl, go);
    exp_t e;
    e.name = nm; e.col = col; e.hp = hp; e.frz = frz; e.fl = fl; e.go = go;
    e.lives = 2'(m_lives); e.score = 14'(m_score); e.hs = 14'(m_hs);
    sb.push_back(e);
  endtask

  task automatic snapshot(input string nm, input logic col, hp, frz, fl, go);
    push(nm, col, hp, frz, fl, go);
    @(posedge clk); #1 snap = 1'b1;
    @(posedge clk); #1 snap = 1'b0;
  endtask

  // One sampled frame; rsp places a respawn pulse on the cycle the result is evaluated.
  task automatic frame(input string nm, input int cx, cy, rx, ry,
                       input logic col, hp, frz, fl, go, input logic rsp);
    push(nm, col, hp, frz, fl, go);
    @(posedge clk); #1;
    car_x = 10'(cx); car_y = 10'(cy); rival_x = 10'(rx); rival_y = 10'(ry);
    frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 rival_respawn = rsp;
    @(posedge clk); #1 rival_respawn = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic respawn(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 rival_respawn = 1'b1;
      @(posedge clk); #1 rival_respawn = 1'b0;
    end
  endtask

  task automatic hit(input string nm, input logic rsp);
    m_lives--;
`ifdef COLLIDE_HIGH_SCORE_EN
    if (m_lives == 0 && m_score > m_hs) m_hs = m_score;
`endif
    frame(nm, 300, 400, 300, 410, 1'b1, 1'b1, 1'b1, 1'b0, logic'(m_lives == 0), rsp);
  endtask

  // Sixty frames of HIT; frame 10 overlaps (ignored), frame 5 carries a respawn (ignored).
  task automatic hit_phase(input string nm);
    for (int k = 1; k <= 60; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      if (k == 10)
        frame(nm, 300, 400, 300, 410, 1'b1, 1'b0, 1'b1, kb[3], 1'b0, 1'b0);
      else
        frame(nm, 0, 0, 500, 0, 1'b0, 1'b0, logic'(k < 60), (k < 60) ? kb[3] : 1'b0, 1'b0,
              logic'(k == 5));
    end
  endtask

  task automatic do_restart(input string nm);
    @(posedge clk); #1 restart = 1'b1;
    m_lives = 3; m_score = 0;
    push(nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 restart = 1'b0; snap = 1'b1;
    @(posedge clk); #1 snap = 1'b0;
  endtask

  task automatic play_to_over(input string nm, input int n_resp);
    respawn(n_resp);
    m_score += n_resp;
    snapshot({nm, "_score"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hit({nm, "_hit1"}, 1'b0);
    hit_phase({nm, "_wait1"});
    hit({nm, "_hit2"}, 1'b1);
    hit_phase({nm, "_wait2"});
    hit({nm, "_hit3"}, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    snapshot("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    frame("edge_x", 300, 400, 332, 400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame("edge_y", 300, 400, 300, 464, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame("edge_in", 0, 0, 500, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    play_to_over("g1", 5);
    frame("over_hold", 300, 400, 300, 410, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    respawn(2);
    snapshot("over_rsp", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    do_restart("restart1");

    play_to_over("g2", 7);
    do_restart("restart2");
    play_to_over("g3", 3);
    do_restart("restart3");

    repeat (5) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
